// File: rtl/lsu_ext_bridge.sv
// Load/store bridge: turns core load/store requests into word-lane memory transactions and formats returned data.
// Optional define LSU_MISALIGN_TRAP_EN flags misaligned accesses instead of force-aligning them.
module lsu_ext_bridge #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [DATA_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] acc_cnt_o
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] acc_cnt;
    logic              cnt_en;

    logic              is_byte, is_half, is_word, is_signed;
    logic              misaligned;
    logic [DATA_W-1:0] eff_addr;
    logic [1:0]        off;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [DATA_W-1:0] load_data;

    // Codes 3, 6 and 7 fall through to word behaviour for lanes and formatting.
    always_comb begin
        is_byte   = (core_size_i == 3'd0) || (core_size_i == 3'd4);
        is_half   = (core_size_i == 3'd1) || (core_size_i == 3'd5);
        is_word   = (core_size_i == 3'd2);
        is_signed = ~core_size_i[2];
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = (is_half && core_addr_i[0]) || (is_word && (core_addr_i[1:0] != 2'b00));
        eff_addr   = core_addr_i;
    end
`else
    // Without the trap, misaligned halves and words are silently issued aligned.
    always_comb begin
        misaligned = 1'b0;
        eff_addr   = core_addr_i;
        if (is_half) begin
            eff_addr[0] = 1'b0;
        end else if (is_word) begin
            eff_addr[1:0] = 2'b00;
        end
    end
`endif

    assign off = eff_addr[1:0];

    always_comb begin
        mem_we_o   = core_we_i;
        mem_addr_o = eff_addr;
        mem_be_o   = 4'b1111;
        mem_wd_o   = core_wd_i;
        if (is_byte) begin
            mem_wd_o = {4{core_wd_i[7:0]}};
            if (core_we_i) begin
                mem_be_o = 4'b0001 << off;
            end
        end else if (is_half) begin
            mem_wd_o = {2{core_wd_i[15:0]}};
            if (core_we_i) begin
                mem_be_o = off[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    always_comb begin
        case (off)
            2'd0:    sel_byte = mem_rd_i[7:0];
            2'd1:    sel_byte = mem_rd_i[15:8];
            2'd2:    sel_byte = mem_rd_i[23:16];
            default: sel_byte = mem_rd_i[31:24];
        endcase
        sel_half = off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

        load_data = mem_rd_i;
        if (is_byte) begin
            load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
        end else if (is_half) begin
            load_data = {{16{is_signed & sel_half[15]}}, sel_half};
        end
    end

    // A request dropped mid-access abandons it without counting.
    always_comb begin
        state_next   = state;
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        misalign_o   = 1'b0;
        core_rd_o    = '0;
        cnt_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_ni && core_req_i) begin
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                        state_next   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_req_o = 1'b1;
                if (!core_req_i) begin
                    state_next = ST_IDLE;
                end else if (mem_ready_i) begin
                    state_next = ST_IDLE;
                    cnt_en     = 1'b1;
                    if (!core_we_i) begin
                        core_rd_o = load_data;
                    end
                end else begin
                    core_stall_o = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            acc_cnt <= '0;
        end else begin
            state <= state_next;
            if (cnt_en) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end

    assign acc_cnt_o = acc_cnt;

endmodule

// File: tb/tb_lsu_ext_bridge.sv
// Directed table-driven bench for lsu_ext_bridge, plus hand sequences for stalls, reset, protocol drop and counter wrap.
`timescale 1ns/1ps
module tb_lsu_ext_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
    logic [31:0] acc_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_cnt;

    lsu_ext_bridge #(.DATA_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .misalign_o(misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i), .acc_cnt_o(acc_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic req, input logic we, input logic [2:0] size,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rdata, input logic ready);
        core_req_i  = req;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rdata;
        mem_ready_i = ready;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // One 2-cycle access: issue cycle, then completion cycle with ready high.
    task automatic run_vec(input vec_t v);
        apply_stimulus(1'b1, v.we, v.size, v.addr, v.wd, 32'h0, 1'b0);
        #1;
        check_output({v.name, " issue req"}, 32'(mem_req_o), 32'd1);
        check_output({v.name, " issue stall"}, 32'(core_stall_o), 32'd1);
        check_output({v.name, " be"}, 32'(mem_be_o), 32'(v.exp_be));
        check_output({v.name, " addr"}, mem_addr_o, v.exp_addr);
        check_output({v.name, " we"}, 32'(mem_we_o), 32'(v.we));
        if (v.we) check_output({v.name, " wd"}, mem_wd_o, v.exp_wd);
        next_cycle();
        mem_ready_i = 1'b1;
        mem_rd_i    = v.rdata;
        #1;
        check_output({v.name, " done stall"}, 32'(core_stall_o), 32'd0);
        check_output({v.name, " rd"}, core_rd_o, v.exp_rd);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        check_output({v.name, " count"}, acc_cnt_o, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{"sb 103",   1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 4'b1000, 32'h103, 32'hA5A5_A5A5, 32'h0};
        vecs[1]  = '{"sh 202",   1'b1, 3'd1, 32'h202, 32'h1234_BEEF, 32'h0, 4'b1100, 32'h202, 32'hBEEF_BEEF, 32'h0};
        vecs[2]  = '{"sh 200",   1'b1, 3'd1, 32'h200, 32'h1234_BEEF, 32'h0, 4'b0011, 32'h200, 32'hBEEF_BEEF, 32'h0};
        vecs[3]  = '{"sw 300",   1'b1, 3'd2, 32'h300, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'h300, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{"lb 102",   1'b0, 3'd0, 32'h102, 32'h0, 32'h12F4_5678, 4'b1111, 32'h102, 32'h0, 32'hFFFF_FFF4};
        vecs[5]  = '{"lbu 102",  1'b0, 3'd4, 32'h102, 32'h0, 32'h12F4_5678, 4'b1111, 32'h102, 32'h0, 32'h0000_00F4};
        vecs[6]  = '{"lb 100",   1'b0, 3'd0, 32'h100, 32'h0, 32'h12F4_5678, 4'b1111, 32'h100, 32'h0, 32'h0000_0078};
        vecs[7]  = '{"lbu 101",  1'b0, 3'd4, 32'h101, 32'h0, 32'h12F4_D678, 4'b1111, 32'h101, 32'h0, 32'h0000_00D6};
        vecs[8]  = '{"lh 000",   1'b0, 3'd1, 32'h000, 32'h0, 32'h8001_FFFF, 4'b1111, 32'h000, 32'h0, 32'hFFFF_FFFF};
        vecs[9]  = '{"lhu 006",  1'b0, 3'd5, 32'h006, 32'h0, 32'h8001_FFFF, 4'b1111, 32'h006, 32'h0, 32'h0000_8001};
        vecs[10] = '{"lw 004",   1'b0, 3'd2, 32'h004, 32'h0, 32'hCAFE_F00D, 4'b1111, 32'h004, 32'h0, 32'hCAFE_F00D};
        vecs[11] = '{"s ill3",   1'b1, 3'd3, 32'h008, 32'h1122_3344, 32'h0, 4'b1111, 32'h008, 32'h1122_3344, 32'h0};
        vecs[12] = '{"l ill7",   1'b0, 3'd7, 32'h00C, 32'h0, 32'h89AB_CDEF, 4'b1111, 32'h00C, 32'h0, 32'h89AB_CDEF};
        vecs[13] = '{"sb 101",   1'b1, 3'd0, 32'h101, 32'hFFFF_FF3C, 32'h0, 4'b0010, 32'h101, 32'h3C3C_3C3C, 32'h0};

        // Reset state, with a request already pending on the core side.
        rst_ni = 1'b0;
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b0);
        exp_cnt = 32'h0;
        #12;
        check_output("reset mem_req", 32'(mem_req_o), 32'd0);
        check_output("reset stall", 32'(core_stall_o), 32'd0);
        check_output("reset misalign", 32'(misalign_o), 32'd0);
        check_output("reset count", acc_cnt_o, 32'h0);
        core_req_i = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        check_output("idle mem_req", 32'(mem_req_o), 32'd0);
        check_output("idle stall", 32'(core_stall_o), 32'd0);

        // Table vectors run back to back with no idle cycles between them.
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end
        core_req_i = 1'b0;
        next_cycle();

        // Halfword load with ready held off for three cycles.
        apply_stimulus(1'b1, 1'b0, 3'd1, 32'h006, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output($sformatf("lh slow stall c%0d", i), 32'(core_stall_o), 32'd1);
            check_output($sformatf("lh slow rd c%0d", i), core_rd_o, 32'h0);
            next_cycle();
        end
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'h8001_FFFF;
        #1;
        check_output("lh slow stall end", 32'(core_stall_o), 32'd0);
        check_output("lh slow rd", core_rd_o, 32'hFFFF_8001);
        next_cycle();
        exp_cnt = exp_cnt + 1;
        check_output("lh slow count", acc_cnt_o, exp_cnt);
        core_req_i = 1'b0;
        next_cycle();

        // Misaligned word and halfword loads.
`ifdef LSU_MISALIGN_TRAP_EN
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h002, 32'h0, 32'h1357_9BDF, 1'b0);
        #1;
        check_output("lw 002 misalign", 32'(misalign_o), 32'd1);
        check_output("lw 002 mem_req", 32'(mem_req_o), 32'd0);
        check_output("lw 002 stall", 32'(core_stall_o), 32'd0);
        check_output("lw 002 rd", core_rd_o, 32'h0);
        next_cycle();
        check_output("lw 002 count", acc_cnt_o, exp_cnt);
        apply_stimulus(1'b1, 1'b0, 3'd5, 32'h003, 32'h0, 32'h0, 1'b0);
        #1;
        check_output("lhu 003 misalign", 32'(misalign_o), 32'd1);
        check_output("lhu 003 mem_req", 32'(mem_req_o), 32'd0);
        core_req_i = 1'b0;
        next_cycle();
`else
        run_vec('{"lw 002", 1'b0, 3'd2, 32'h002, 32'h0, 32'h1357_9BDF, 4'b1111, 32'h000, 32'h0, 32'h1357_9BDF});
        check_output("lw 002 misalign", 32'(misalign_o), 32'd0);
        run_vec('{"lhu 003", 1'b0, 3'd5, 32'h003, 32'h0, 32'hA5B6_0000, 4'b1111, 32'h002, 32'h0, 32'h0000_A5B6});
        run_vec('{"sh 001", 1'b1, 3'd1, 32'h001, 32'h0000_CAFE, 32'h0, 4'b0011, 32'h000, 32'hCAFE_CAFE, 32'h0});
        core_req_i = 1'b0;
        next_cycle();
`endif

        // Request dropped while waiting: access abandoned, not counted.
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h010, 32'h0, 32'h0, 1'b0);
        next_cycle();
        core_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        next_cycle();
        check_output("drop count", acc_cnt_o, exp_cnt);
        mem_ready_i = 1'b0;
        #1;
        check_output("drop idle req", 32'(mem_req_o), 32'd0);
        next_cycle();

        // Reset asserted mid-access aborts it and clears the count.
        apply_stimulus(1'b1, 1'b1, 3'd2, 32'h020, 32'h5555_AAAA, 32'h0, 1'b0);
        next_cycle();
        rst_ni = 1'b0;
        #1;
        check_output("rst wait mem_req", 32'(mem_req_o), 32'd0);
        check_output("rst wait stall", 32'(core_stall_o), 32'd0);
        check_output("rst wait count", acc_cnt_o, 32'h0);
        exp_cnt = 32'h0;
        next_cycle();
        rst_ni = 1'b1;
        #1;
        check_output("post rst issue req", 32'(mem_req_o), 32'd1);
        run_vec('{"post rst sw", 1'b1, 3'd2, 32'h020, 32'h5555_AAAA, 32'h0, 4'b1111, 32'h020, 32'h5555_AAAA, 32'h0});
        core_req_i = 1'b0;
        next_cycle();

        // Counter wrap from all-ones back to zero.
        force dut.acc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.acc_cnt;
        #1;
        check_output("preload count", acc_cnt_o, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        next_cycle();
        run_vec('{"wrap lw", 1'b0, 3'd2, 32'h040, 32'h0, 32'h0BAD_F00D, 4'b1111, 32'h040, 32'h0, 32'h0BAD_F00D});
        check_output("wrap zero", acc_cnt_o, 32'h0);
        core_req_i = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
